// File: rtl/vga_timing_pkg.sv
// 800x600@72 raster constants shared by the VGA timing path.
package vga_timing_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 56;
  localparam int H_SYNC   = 120;
  localparam int H_BP     = 64;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 37;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 23;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int H_DIV    = 4;
  localparam int H_BITS   = 9;
  localparam int V_BITS   = 10;

endpackage

// File: rtl/mod_counter.sv
// ce-gated mod-N counter. Exposes the value it will hold after this edge
// (nxt) so downstream decoders can register outputs in step with the count.
module mod_counter #(
  parameter int N    = 2,
  parameter int W    = (N > 1) ? $clog2(N) : 1,
  parameter int LOAD = N - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  output logic [W-1:0] nxt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST   = W'(N - 1);
  localparam logic [W-1:0] LOAD_V = W'(LOAD);

  logic [W-1:0] cnt;

  // wrap: this enabled edge takes the count from N-1 back to 0
  assign wrap = ce && (cnt == LAST);

  // value the register takes at the coming edge
  always_comb begin
    nxt = cnt;
    if (!rst_n)  nxt = LOAD_V;
    else if (ce) nxt = (cnt == LAST) ? '0 : cnt + W'(1);
  end

  // count register, synchronous reload on reset
  always_ff @(posedge clk) begin
    if (!rst_n)  cnt <= LOAD_V;
    else if (ce) cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: h/v counters plus registered decoders driven from
// the next count, so every output describes the current counter position.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE_P = H_ACTIVE,
  parameter int   H_FP_P     = H_FP,
  parameter int   H_SYNC_P   = H_SYNC,
  parameter int   H_BP_P     = H_BP,
  parameter int   V_ACTIVE_P = V_ACTIVE,
  parameter int   V_FP_P     = V_FP,
  parameter int   V_SYNC_P   = V_SYNC,
  parameter int   V_BP_P     = V_BP,
  parameter int   H_DIV_P    = H_DIV,
  parameter logic SYNC_POL   = 1'b1,
  parameter int   H_BITS_P   = H_BITS,
  parameter int   V_BITS_P   = V_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  output logic [H_BITS_P-1:0] h_index,
  output logic [V_BITS_P-1:0] v_index,
  output logic                pre_h_porch,
  output logic                h_porch,
  output logic                video_on,
  output logic                hsync,
  output logic                vsync,
  output logic                frame_start
);

  localparam int HT = H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P;
  localparam int VT = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int SH = $clog2(H_DIV_P);

  localparam logic [HW-1:0] HA_L  = HW'(H_ACTIVE_P);
  localparam logic [HW-1:0] HA_M1 = HW'(H_ACTIVE_P - 1);
  localparam logic [HW-1:0] HT_M2 = HW'(HT - 2);
  localparam logic [HW-1:0] HS0   = HW'(H_ACTIVE_P + H_FP_P);
  localparam logic [HW-1:0] HS1   = HW'(H_ACTIVE_P + H_FP_P + H_SYNC_P);
  localparam logic [VW-1:0] VA_L  = VW'(V_ACTIVE_P);
  localparam logic [VW-1:0] VS0   = VW'(V_ACTIVE_P + V_FP_P);
  localparam logic [VW-1:0] VS1   = VW'(V_ACTIVE_P + V_FP_P + V_SYNC_P);

  logic [HW-1:0] h_nxt, h_sh;
  logic [VW-1:0] v_nxt;
  logic          h_wrap, v_wrap, v_ce;
  logic          h_act, v_act, in_hs, in_vs, in_pre;

  mod_counter #(.N(HT)) u_hcnt (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (ce),
    .nxt  (h_nxt),
    .wrap (h_wrap)
  );

  assign v_ce = ce & h_wrap;

  // v_wrap implies h_wrap, so it marks the frame wrap into (0,0)
  mod_counter #(.N(VT)) u_vcnt (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (v_ce),
    .nxt  (v_nxt),
    .wrap (v_wrap)
  );

  // decode the position the counters move to at this edge
  always_comb begin
    h_act  = (h_nxt < HA_L);
    v_act  = (v_nxt < VA_L);
    in_hs  = (h_nxt >= HS0) && (h_nxt < HS1);
    in_vs  = (v_nxt >= VS0) && (v_nxt < VS1);
    in_pre = (h_nxt >= HA_M1) && (h_nxt <= HT_M2);
    h_sh   = h_nxt >> SH;
  end

  // registered outputs; reset parks on the last blank pixel, ce=0 holds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_index     <= '0;
      v_index     <= '0;
      pre_h_porch <= 1'b1;
      h_porch     <= 1'b1;
      video_on    <= 1'b0;
      hsync       <= !SYNC_POL;
      vsync       <= !SYNC_POL;
      frame_start <= 1'b0;
    end else if (ce) begin
      h_index     <= h_act ? H_BITS_P'(h_sh) : '0;
      v_index     <= v_act ? V_BITS_P'(v_nxt) : '0;
      pre_h_porch <= in_pre;
      h_porch     <= !h_act;
      video_on    <= h_act && v_act;
      hsync       <= in_hs ? SYNC_POL : !SYNC_POL;
      vsync       <= in_vs ? SYNC_POL : !SYNC_POL;
      frame_start <= v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance (line-level behaviour) and a
// shrunk instance (frame-level behaviour) checked every cycle against a
// position-index reference model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] b_hi, s_hi;
  logic [9:0] b_vi, s_vi;
  logic b_pre, b_hp, b_von, b_hs, b_vs, b_fs;
  logic s_pre, s_hp, s_von, s_hs, s_vs, s_fs;

  vga_timing_gen u_big (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .h_index(b_hi), .v_index(b_vi), .pre_h_porch(b_pre), .h_porch(b_hp),
    .video_on(b_von), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE_P(16), .H_FP_P(4), .H_SYNC_P(6), .H_BP_P(6),
    .V_ACTIVE_P(8),  .V_FP_P(2), .V_SYNC_P(3), .V_BP_P(2)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .h_index(s_hi), .v_index(s_vi), .pre_h_porch(s_pre), .h_porch(s_hp),
    .video_on(s_von), .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs)
  );

  // timing tables: index 0 = full size, index 1 = shrunk
  int c_ha[2]  = '{800, 16};
  int c_hfp[2] = '{56, 4};
  int c_hs[2]  = '{120, 6};
  int c_hbp[2] = '{64, 6};
  int c_va[2]  = '{600, 8};
  int c_vfp[2] = '{37, 2};
  int c_vs[2]  = '{6, 3};
  int c_vbp[2] = '{23, 2};

  // model state: linear pixel index within the frame, reset-parked flag, frame_start
  int p[2];
  bit rs[2];
  bit fs[2];

  int total = 0;
  int bad = 0;

  int b_hs_n, b_hp_n, b_pre_n, s_von_n, s_vs_n, s_fs_n;

  typedef struct {
    int hi, vi, pre, hp, von, hs, vs, fs;
  } exp_t;

  function automatic int htot(int i);
    return c_ha[i] + c_hfp[i] + c_hs[i] + c_hbp[i];
  endfunction

  function automatic int vtot(int i);
    return c_va[i] + c_vfp[i] + c_vs[i] + c_vbp[i];
  endfunction

  function automatic exp_t model_out(int i);
    exp_t e;
    int ht, h, v;
    ht = htot(i);
    h = p[i] % ht;
    v = p[i] / ht;
    e.hi  = (h < c_ha[i]) ? h / 4 : 0;
    e.vi  = (v < c_va[i]) ? v : 0;
    e.pre = rs[i] ? 1 : ((h >= c_ha[i] - 1) && (h <= ht - 2));
    e.hp  = (h >= c_ha[i]);
    e.von = (h < c_ha[i]) && (v < c_va[i]);
    e.hs  = (h >= c_ha[i] + c_hfp[i]) && (h < c_ha[i] + c_hfp[i] + c_hs[i]);
    e.vs  = (v >= c_va[i] + c_vfp[i]) && (v < c_va[i] + c_vfp[i] + c_vs[i]);
    e.fs  = fs[i];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_inst(input int i, input string nm,
                          input logic [8:0] hi, input logic [9:0] vi,
                          input logic pre, input logic hp, input logic von,
                          input logic hs, input logic vs, input logic fsv);
    exp_t e;
    e = model_out(i);
    chk({nm, ".h_index"}, 32'(hi), e.hi);
    chk({nm, ".v_index"}, 32'(vi), e.vi);
    chk({nm, ".pre_h_porch"}, 32'(pre), e.pre);
    chk({nm, ".h_porch"}, 32'(hp), e.hp);
    chk({nm, ".video_on"}, 32'(von), e.von);
    chk({nm, ".hsync"}, 32'(hs), e.hs);
    chk({nm, ".vsync"}, 32'(vs), e.vs);
    chk({nm, ".frame_start"}, 32'(fsv), e.fs);
  endtask

  // one clock: drive inputs, advance the model, check both instances
  task automatic step(input logic r, input logic c);
    rst_n = r;
    ce = c;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        p[i] = htot(i) * vtot(i) - 1;
        rs[i] = 1'b1;
        fs[i] = 1'b0;
      end else if (c) begin
        p[i] = (p[i] + 1) % (htot(i) * vtot(i));
        rs[i] = 1'b0;
        fs[i] = (p[i] == 0);
      end
    end
    #1;
    chk_inst(0, "big", b_hi, b_vi, b_pre, b_hp, b_von, b_hs, b_vs, b_fs);
    chk_inst(1, "small", s_hi, s_vi, s_pre, s_hp, s_von, s_hs, s_vs, s_fs);
    b_hs_n  += int'(b_hs);
    b_hp_n  += int'(b_hp);
    b_pre_n += int'(b_pre);
    s_von_n += int'(s_von);
    s_vs_n  += int'(s_vs);
    s_fs_n  += int'(s_fs);
  endtask

  initial begin
    int n;
    int sv_von, sv_vs, sv_fs;
    sv_von = 0; sv_vs = 0; sv_fs = 0;

    // reset for three clocks
    repeat (3) step(1'b0, 1'b1);

    // first enabled pixel after release, then one full line of the big raster
    b_hs_n = 0; b_hp_n = 0; b_pre_n = 0; s_von_n = 0; s_vs_n = 0; s_fs_n = 0;
    for (int k = 0; k < 1040; k++) begin
      step(1'b1, 1'b1);
      if (k == 0) begin
        chk("first.video_on", 32'(b_von), 1);
        chk("first.frame_start", 32'(b_fs), 1);
        chk("first.v_index", 32'(b_vi), 0);
      end
      if (k <= 3) chk("hidx.lo", 32'(b_hi), 0);
      if (k >= 796 && k <= 799) chk("hidx.hi", 32'(b_hi), 199);
      if (k == 800) chk("hidx.porch", 32'(b_hi), 0);
      if (k == 799) chk("pre.rise", 32'(b_pre), 1);
      if (k == 800) chk("hporch.rise", 32'(b_hp), 1);
      if (k == 479) begin
        sv_von = s_von_n; sv_vs = s_vs_n; sv_fs = s_fs_n;
      end
    end
    chk("line.hsync_clks", 32'(b_hs_n), 120);
    chk("line.h_porch_clks", 32'(b_hp_n), 240);
    chk("line.pre_clks", 32'(b_pre_n), 240);
    chk("frame.video_on_clks", 32'(sv_von), 16 * 8);
    chk("frame.vsync_clks", 32'(sv_vs), 3 * 32);
    chk("frame.frame_starts", 32'(sv_fs), 1);

    // 50% random ce: outputs hold on idle cycles
    repeat (4000) step(1'b1, 1'($urandom_range(0, 1)));

    // mid-frame reset, idle after release, then the first enabled edge lands on (0,0)
    n = $urandom_range(50, 700);
    repeat (n) step(1'b1, 1'b1);
    step(1'b0, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("rst.h_index", 32'(b_hi), 0);
    chk("rst.v_index", 32'(b_vi), 0);
    chk("rst.frame_start", 32'(b_fs), 1);
    chk("rst.small_frame_start", 32'(s_fs), 1);

    // random ce with occasional resets
    repeat (3000) step(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
